// File: rtl/dut_dbg_target_if.sv
// rtl/dut_dbg_target_if.sv - terminal-side debug bus between the user terminal and the DUT responder
interface dut_dbg_target_if;
  logic [15:0] taddr;
  logic [31:0] tdout;
  logic        twe;
  logic        tclk;
  logic [31:0] tdin;
  logic        busy;
  logic        done;

  modport master (
    output taddr, tdout, twe, tclk,
    input  tdin, busy, done
  );

  modport slave (
    input  taddr, tdout, twe, tclk,
    output tdin, busy, done
  );
endinterface

// File: rtl/dut_dbg_target.sv
// rtl/dut_dbg_target.sv - debug register map: scratch RAM, step/write counters, ID and step-driven countdown
module dut_dbg_target #(
  parameter logic [31:0] ID_VALUE = 32'h5554_0001,
  parameter int          RAM_AW   = 4
) (
  input logic             clk,
  input logic             rst,
  dut_dbg_target_if.slave dbg
);
  localparam logic [15:0] A_STEP_CNT  = 16'h0010;
  localparam logic [15:0] A_WR_CNT    = 16'h0011;
  localparam logic [15:0] A_LAST_ADDR = 16'h0012;
  localparam logic [15:0] A_ID        = 16'h0013;
  localparam logic [15:0] A_CD_LOAD   = 16'h0014;
  localparam logic [15:0] A_CD_STAT   = 16'h0015;
  localparam logic [16:0] RAM_WORDS   = 17'(1 << RAM_AW);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] remaining;
  logic [31:0] step_cnt;
  logic [31:0] wr_cnt;
  logic [15:0] last_addr;
  logic [31:0] ram [RAM_WORDS];
  logic [31:0] rd_data;
  logic        ram_hit;
  logic        wr_step;
  logic        wr_cd_load;
  logic        wr_cd_stat;

  // RAM only occupies the low block and only as far as RAM_AW reaches
  assign ram_hit    = (dbg.taddr[15:4] == 12'h000) && ({1'b0, dbg.taddr} < RAM_WORDS);
  assign wr_step    = dbg.twe && (dbg.taddr == A_STEP_CNT);
  assign wr_cd_load = dbg.twe && (dbg.taddr == A_CD_LOAD);
  assign wr_cd_stat = dbg.twe && (dbg.taddr == A_CD_STAT);

  always_ff @(posedge clk) begin
    if (dbg.twe && ram_hit) begin
      ram[dbg.taddr[RAM_AW-1:0]] <= dbg.tdout;
    end
  end

  always_comb begin
    rd_data = 32'h0;
    if (ram_hit) begin
      rd_data = ram[dbg.taddr[RAM_AW-1:0]];
    end else begin
      case (dbg.taddr)
        A_STEP_CNT:  rd_data = step_cnt;
        A_WR_CNT:    rd_data = wr_cnt;
        A_LAST_ADDR: rd_data = {16'h0, last_addr};
        A_ID:        rd_data = ID_VALUE;
        A_CD_LOAD:   rd_data = remaining;
        A_CD_STAT:   rd_data = {30'b0, dbg.done, dbg.busy};
        default:     rd_data = 32'h0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_cnt  <= 32'h0;
      wr_cnt    <= 32'h0;
      last_addr <= 16'h0;
      dbg.tdin  <= 32'h0;
    end else begin
      dbg.tdin <= rd_data;
      if (wr_step) begin
        step_cnt <= dbg.tdout;
      end else if (dbg.tclk) begin
        step_cnt <= step_cnt + 32'd1;
      end
      if (dbg.twe) begin
        wr_cnt    <= wr_cnt + 32'd1;
        last_addr <= dbg.taddr;
      end
    end
  end

  // A CD_LOAD write overrides whatever the step pulse would have done this cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      remaining <= 32'h0;
      dbg.busy  <= 1'b0;
      dbg.done  <= 1'b0;
    end else if (wr_cd_load) begin
      remaining <= dbg.tdout;
      if (dbg.tdout != 32'h0) begin
        state    <= S_RUN;
        dbg.busy <= 1'b1;
        dbg.done <= 1'b0;
      end else begin
        state    <= S_DONE;
        dbg.busy <= 1'b0;
        dbg.done <= 1'b1;
      end
    end else begin
      case (state)
        S_RUN: begin
          if (dbg.tclk) begin
            remaining <= remaining - 32'd1;
            if (remaining == 32'd1) begin
              state    <= S_DONE;
              dbg.busy <= 1'b0;
              dbg.done <= 1'b1;
            end
          end
        end
        S_DONE: begin
          if (wr_cd_stat) begin
            state    <= S_IDLE;
            dbg.done <= 1'b0;
          end
        end
        default: begin
          state    <= S_IDLE;
          dbg.busy <= 1'b0;
          dbg.done <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_dut_dbg_target.sv
// tb/tb_dut_dbg_target.sv - scoreboard bench for dut_dbg_target with a register-map reference model
module tb_dut_dbg_target;
  logic clk = 1'b0;
  logic rst = 1'b1;

  dut_dbg_target_if dbg ();

  dut_dbg_target #(
    .ID_VALUE(32'h5554_0001),
    .RAM_AW  (4)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .dbg(dbg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] tdin;
    bit          chk_tdin;
    bit          busy;
    bit          done;
    string       tag;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // reference model: plain values, mode 0=idle 1=run 2=done
  logic [31:0] m_ram [16];
  bit          m_ram_ok [16];
  logic [31:0] m_step, m_wr, m_rem;
  logic [15:0] m_last;
  int          m_mode;

  task automatic model_reset();
    m_step = 0; m_wr = 0; m_rem = 0; m_last = 0; m_mode = 0;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  // one clock cycle: drive at negedge, predict the post-edge outputs, then advance
  task automatic step(input logic [15:0] a, input logic [31:0] d, input bit we, input bit tc,
                      input string tag);
    exp_t e;
    dbg.taddr = a; dbg.tdout = d; dbg.twe = we; dbg.tclk = tc;
    e.tag = tag;
    e.chk_tdin = 1'b1;
    if (rst) begin
      model_reset();
      e.tdin = 0;
    end else begin
      e.tdin = 0;
      if (a < 16) begin
        e.tdin = m_ram[a[3:0]];
        e.chk_tdin = m_ram_ok[a[3:0]];
      end else if (a == 16'h10) e.tdin = m_step;
      else if (a == 16'h11) e.tdin = m_wr;
      else if (a == 16'h12) e.tdin = {16'h0, m_last};
      else if (a == 16'h13) e.tdin = 32'h5554_0001;
      else if (a == 16'h14) e.tdin = m_rem;
      else if (a == 16'h15) e.tdin = {30'b0, m_mode == 2, m_mode == 1};

      if (we && a == 16'h10) m_step = d;
      else if (tc) m_step = m_step + 1;
      if (we) begin
        m_wr = m_wr + 1;
        m_last = a;
        if (a < 16) begin
          m_ram[a[3:0]] = d;
          m_ram_ok[a[3:0]] = 1'b1;
        end
      end
      if (we && a == 16'h14) begin
        m_rem = d;
        m_mode = (d != 0) ? 1 : 2;
      end else if (m_mode == 1 && tc) begin
        m_rem = m_rem - 1;
        if (m_rem == 0) m_mode = 2;
      end else if (m_mode == 2 && we && a == 16'h15) begin
        m_mode = 0;
      end
    end
    e.busy = (m_mode == 1);
    e.done = (m_mode == 2);
    q.push_back(e);
    @(negedge clk);
  endtask

  always begin
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      if (e.chk_tdin) check({e.tag, " tdin"}, dbg.tdin, e.tdin);
      check({e.tag, " busy"}, {31'b0, dbg.busy}, {31'b0, e.busy});
      check({e.tag, " done"}, {31'b0, dbg.done}, {31'b0, e.done});
    end
  end

  task automatic async_reset();
    rst = 1'b1;
    #1;
    check("async rst busy", {31'b0, dbg.busy}, 32'h0);
    check("async rst done", {31'b0, dbg.done}, 32'h0);
    check("async rst tdin", dbg.tdin, 32'h0);
    #3;
    step(16'h0, 0, 0, 0, "rst hold");
    step(16'h0, 0, 0, 0, "rst hold");
    rst = 1'b0;
  endtask

  initial begin
    logic [15:0] a;
    logic [31:0] d;
    bit          we, tc;
    for (int i = 0; i < 16; i++) m_ram_ok[i] = 1'b0;
    model_reset();
    dbg.taddr = 0; dbg.tdout = 0; dbg.twe = 0; dbg.tclk = 0;
    @(negedge clk);
    step(16'h13, 0, 0, 0, "reset");
    step(16'h13, 0, 0, 0, "reset");
    rst = 1'b0;
    step(16'h13, 0, 0, 0, "read id");
    step(16'h12, 0, 0, 0, "read last_addr");

    step(16'h3, 32'hCAFE_0001, 1, 0, "ram write");
    step(16'h3, 0, 0, 0, "ram rd1");
    step(16'h3, 0, 0, 0, "ram rd2");
    step(16'h11, 0, 0, 0, "wr_cnt");
    step(16'h12, 0, 0, 0, "last_addr");

    step(16'h10, 32'hFFFF_FFFE, 1, 0, "step load");
    for (int i = 0; i < 3; i++) step(16'h10, 0, 0, 1, "step wrap");
    step(16'h10, 0, 0, 0, "step after wrap");

    step(16'h14, 32'd3, 1, 0, "cd load 3");
    for (int i = 0; i < 4; i++) step(16'h14, 0, 0, 1, "cd count");
    step(16'h14, 0, 0, 0, "cd rem");
    step(16'h15, 0, 1, 0, "cd stat clear");
    step(16'h15, 0, 0, 0, "cd stat read");

    step(16'h14, 32'd5, 1, 1, "cd load vs tclk");
    step(16'h14, 0, 0, 0, "cd rem 5");
    step(16'h10, 32'd7, 1, 1, "step write vs tclk");
    step(16'h10, 0, 0, 0, "step 7");

    step(16'h14, 32'd2, 1, 0, "cd load 2");
    step(16'h14, 0, 0, 1, "cd tick");
    async_reset();
    step(16'h15, 0, 0, 1, "tclk after rst");
    step(16'h15, 0, 0, 0, "stat after rst");
    step(16'h14, 0, 1, 0, "cd load 0");
    step(16'h14, 0, 0, 0, "cd rem 0");

    for (int i = 0; i < 16; i++) step(i[15:0], $urandom, 1, 0, "ram fill");
    for (int i = 0; i < 600; i++) begin
      a  = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'($urandom_range(0, 23));
      we = ($urandom_range(0, 3) == 0);
      tc = ($urandom_range(0, 2) == 0);
      d  = $urandom;
      if (a == 16'h14) d = $urandom_range(0, 6);
      if (a == 16'h10 && $urandom_range(0, 1) == 1) d = 32'hFFFF_FFFF - $urandom_range(0, 3);
      step(a, d, we, tc, "random");
    end
    step(16'h0, 0, 0, 0, "drain");
    check("queue drained", q.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/dut_dbg_target.md
# dut_dbg_target

DUT-side responder for the board debug interface; it is the far end of the user terminal. It samples `taddr`, `tdout`, `twe` and the single-cycle `tclk` step pulses, and holds a small register map. The map contains scratch RAM, step and write counters, an ID word and a step-driven countdown FSM. It returns the addressed word on `tdin` for display on the seven-segment digits.

## Interface
- `ID_VALUE`, 32'h5554_0001, constant returned at address 0x0013
- `RAM_AW`, 4, scratch RAM address width (2^RAM_AW words, 32 bits each)
- `clk`  in  1  system clock, 100 MHz
- `rst`  in  1  reset; asynchronous, active-high
- `taddr`  in  16  word address from the terminal
- `tdout`  in  32  write data from the terminal
- `twe`  in  1  write strobe; a one-`clk` pulse, each pulse is one write
- `tclk`  in  1  step pulse; one `clk` high per step, synchronous to `clk`
- `tdin`  out  32  registered read data for `taddr`
- `busy`  out  1  countdown FSM is in RUN
- `done`  out  1  countdown FSM is in DONE

## Operation
Register map (word addresses):
- 0x0000–0x000F: scratch RAM, R/W. Only addresses below 2^RAM_AW are mapped.
- 0x0010 STEP_CNT: increments by 1 on each cycle with `tclk`=1. Wraps from 0xFFFFFFFF to 0. A write loads it.
- 0x0011 WR_CNT: increments on every `twe` pulse, mapped or not, including writes to itself. Wraps. Writes do not load it.
- 0x0012 LAST_ADDR: {16'h0, `taddr`} of the most recent `twe`.
- 0x0013 ID: returns ID_VALUE. Read-only.
- 0x0014 CD_LOAD: a write starts the countdown. A read returns the remaining count.
- 0x0015 CD_STAT: reads {30'b0, done, busy}. Any write clears DONE to IDLE.
- All other addresses: read 32'h0. Writes are ignored apart from WR_CNT and LAST_ADDR.

Countdown FSM, states IDLE / RUN / DONE:
- Write N to CD_LOAD, from any state:
  - N≠0: go to RUN with remaining = N.
  - N=0: go directly to DONE with remaining = 0.
- In RUN, each `tclk` pulse decrements remaining.
  - A pulse that takes remaining from 1 to 0 moves the FSM to DONE.
- DONE is sticky. It leaves DONE only on a CD_STAT write (to IDLE) or a CD_LOAD write.
- `tclk` pulses in IDLE or DONE do not change remaining. They still advance STEP_CNT.

Simultaneous events:
- `twe` and `tclk` in the same cycle:
  - A write to STEP_CNT wins over the increment; the written value is stored.
  - A write to CD_LOAD wins over the decrement; no decrement happens that cycle.
  - A CD_STAT write while in RUN is ignored by the FSM.
- `twe` held high for several cycles counts as that many writes. The terminal never does this; it is defined behaviour anyway.

## Timing
- Reset values:
  - `tdin`=0, `busy`=0, `done`=0.
  - STEP_CNT, WR_CNT, LAST_ADDR, remaining all 0; FSM in IDLE.
  - RAM contents are not reset; the bench must write before reading.
- Writes commit on the `clk` edge where `twe`=1, using `taddr` and `tdout` sampled at that edge. The terminal clears its address on the same edge; the pre-edge value is the one used.
- `tdin` is registered, one cycle behind `taddr`:
  - At each edge, `tdin` takes the pre-edge contents at the pre-edge `taddr`.
  - After a write at edge E, `tdin` shows the new value from edge E+1, provided `taddr` still selects it.
- `busy` and `done` are decoded directly from state flops and change on the same edge as the transition.
- Reset mid-RUN returns to IDLE immediately, asynchronously. The next `tclk` pulse has no effect on the FSM.

## Test plan
- Reset, then read addresses 0x0013 and 0x0012 -> `tdin`=0 during reset, then 0x5554_0001 and 0x0000_0000; `busy`=`done`=0.
- Write 0xCAFE_0001 to 0x0003, then hold `taddr`=0x0003 -> `tdin`=0xCAFE_0001 from the second edge after `twe`. WR_CNT reads 1 and LAST_ADDR reads 0x0000_0003.
- Write 0xFFFF_FFFE to 0x0010, then apply 3 `tclk` pulses -> STEP_CNT reads 0xFFFF_FFFF, then 0, then 1 (wrap).
- Write 3 to 0x0014, then apply 3 `tclk` pulses -> `busy`=1 and remaining reads 2, 1; after the third pulse, `done`=1, `busy`=0, remaining=0. A fourth pulse leaves remaining=0. Writing 0 to 0x0015 gives CD_STAT=0.
- Write 5 to 0x0014 with `twe` and `tclk` in the same cycle -> remaining=5 and `busy`=1. Also write 7 to 0x0010 with `tclk` in the same cycle -> STEP_CNT=7.
- Write 2 to 0x0014, apply one `tclk` pulse, then assert `rst` -> `busy`/`done`=0 and remaining=0 immediately. A later `tclk` pulse leaves CD_STAT=0; write 0 to 0x0014 -> `done`=1.
